aes_dec_stream_ctrl: RTL and testbench

Sequential stream controller wrapped around the combinational AES-128 decryption datapath. It packs 32-bit ciphertext words into 128-bit blocks and holds the block and cipher key stable across a multicycle settle window. It then captures the decrypted block, optionally applies CBC chaining, and streams the plaintext out as 32-bit words with valid/ready handshakes. It sits directly upstream of the decryption datapath, driving its ciphertext and key inputs, and directly downstream of it, consuming its plaintext output.

---
 rtl/aes_dec_stream_if.sv | 21 ++
 rtl/aes_dec_stream_ctrl.sv | 76 +++++++
 tb/tb_aes_dec_stream_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_stream_if.sv
// aes_dec_stream_if: 32-bit ciphertext-in / plaintext-out valid/ready stream pair
//   in_data/in_valid/in_ready     ciphertext words into the controller
//   out_data/out_valid/out_ready  plaintext words out of the controller
//   out_last                      marks the 4th word of each block
interface aes_dec_stream_if;
  logic [31:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport slave (
    input in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
  modport master (
    output in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/aes_dec_stream_ctrl.sv
// aes_dec_stream_ctrl: packs ciphertext words into blocks around a combinational AES-128 decryptor
//   clk, rst            clock, asynchronous active-high reset
//   key_in/key_load     cipher key load (only while idle)
//   iv_in/iv_load       CBC chain load (only while idle)
//   strm                word streams (slave side)
//   busy                block collection or processing in progress
//   dec_en_msg/dec_key  held block and key into the datapath
//   dec_de_msg          datapath plaintext
module aes_dec_stream_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter bit CBC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic [127:0] key_in,
  input  logic key_load,
  input  logic [127:0] iv_in,
  input  logic iv_load,
  aes_dec_stream_if.slave strm,
  output logic busy,
  output logic [127:0] dec_en_msg,
  output logic [127:0] dec_key,
  input  logic [127:0] dec_de_msg
);
  typedef enum logic [1:0] {COLLECT, SETTLE, DRAIN} state_t;
  state_t state, state_n;
  // word count while collecting, word index while draining
  logic [1:0] cnt;
  logic [7:0] timer;
  // word 0 of a block sits in the top slot, so slot number is ~cnt
  logic [3:0][31:0] blk, pt;
  logic [127:0] key, chain;
  logic idle, acc, hs, fire;
  assign idle = state == COLLECT && cnt == 2'd0;
  assign acc = state == COLLECT && strm.in_valid;
  assign hs = state == DRAIN && strm.out_ready;
  assign fire = state == SETTLE && timer == 8'd1;
  assign strm.in_ready = state == COLLECT;
  assign strm.out_valid = state == DRAIN;
  assign strm.out_last = state == DRAIN && cnt == 2'd3;
  assign strm.out_data = pt[~cnt];
  assign busy = state != COLLECT || cnt != 2'd0;
  assign dec_en_msg = blk;
  assign dec_key = key;
  always_comb begin
    state_n = state;
    if (acc && cnt == 2'd3) state_n = SETTLE;
    if (fire) state_n = DRAIN;
    if (hs && cnt == 2'd3) state_n = COLLECT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      timer <= '0;
      blk <= '0;
      pt <= '0;
      key <= '0;
      chain <= '0;
    end else begin
      state <= state_n;
      if (idle && key_load) key <= key_in;
      if (idle && iv_load) chain <= iv_in;
      if (acc) begin
        blk[~cnt] <= strm.in_data;
        cnt <= cnt + 2'd1;
      end
      if (acc && cnt == 2'd3) timer <= 8'(SETTLE_CYCLES);
      if (state == SETTLE) timer <= timer - 8'd1;
      if (fire) begin
        pt <= dec_de_msg ^ (CBC_EN ? chain : '0);
        if (CBC_EN) chain <= blk;
      end
      if (hs) cnt <= cnt + 2'd1;
    end
endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// tb_aes_dec_stream_ctrl: vectors, corner sequences and random blocks against an AES/CBC stream model
module tb_aes_dec_stream_ctrl;
  localparam int NI = 3;
  localparam int ST [NI] = '{4, 4, 1};
  localparam bit CB [NI] = '{1'b0, 1'b1, 1'b1};
  localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
  logic clk = 1'b0;
  logic rst;
  logic [127:0] key_in, iv_in;
  logic key_load, iv_load;
  logic [31:0] in_data;
  logic in_valid, out_ready;
  logic [1:0] sel;
  logic [NI-1:0] in_ready_v, out_valid_v, out_last_v, busy_v;
  logic [NI-1:0][31:0] out_data_v;
  logic [NI-1:0][127:0] enc_v, dkey_v;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
  endfunction
  // FIPS-197 inverse cipher; byte k of the state is block byte k, column-major
  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [31:0] x;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ w[40 + k/4][31-8*(k%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c-q+4)%4)+q];
      for (int k = 0; k < 16; k++) s[k] = isbox(t[k]) ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
          s[4*c]   = gmul(t[0], 8'h0e) ^ gmul(t[1], 8'h0b) ^ gmul(t[2], 8'h0d) ^ gmul(t[3], 8'h09);
          s[4*c+1] = gmul(t[0], 8'h09) ^ gmul(t[1], 8'h0e) ^ gmul(t[2], 8'h0b) ^ gmul(t[3], 8'h0d);
          s[4*c+2] = gmul(t[0], 8'h0d) ^ gmul(t[1], 8'h09) ^ gmul(t[2], 8'h0e) ^ gmul(t[3], 8'h0b);
          s[4*c+3] = gmul(t[0], 8'h0b) ^ gmul(t[1], 8'h0d) ^ gmul(t[2], 8'h09) ^ gmul(t[3], 8'h0e);
        end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_dec_stream_if bus ();
    logic [127:0] dde;
    assign bus.in_data = in_data;
    assign bus.in_valid = in_valid && sel == 2'(g);
    assign bus.out_ready = out_ready;
    assign in_ready_v[g] = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign out_last_v[g] = bus.out_last;
    assign out_data_v[g] = bus.out_data;
    assign dde = aes_dec(enc_v[g], dkey_v[g]);
    aes_dec_stream_ctrl #(.SETTLE_CYCLES(ST[g]), .CBC_EN(CB[g])) dut (
      .clk(clk), .rst(rst),
      .key_in(key_in), .key_load(key_load && sel == 2'(g)),
      .iv_in(iv_in), .iv_load(iv_load && sel == 2'(g)),
      .strm(bus), .busy(busy_v[g]),
      .dec_en_msg(enc_v[g]), .dec_key(dkey_v[g]), .dec_de_msg(dde)
    );
  end

  logic cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
  logic [31:0] cur_out_data;
  logic [127:0] cur_enc, cur_dkey;
  assign cur_in_ready = in_ready_v[sel];
  assign cur_out_valid = out_valid_v[sel];
  assign cur_out_last = out_last_v[sel];
  assign cur_busy = busy_v[sel];
  assign cur_out_data = out_data_v[sel];
  assign cur_enc = enc_v[sel];
  assign cur_dkey = dkey_v[sel];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, required a DUT response", name);
  endtask

  // Reference model: per-instance key/chain, the block being gathered and the words still owed
  logic [127:0] m_key [NI];
  logic [127:0] m_chain [NI];
  logic [127:0] m_blk, m_pt;
  int m_words, lat_cnt;
  bit lat_wait, hold, m_idle;
  logic [31:0] hold_data;
  logic hold_last;
  logic [32:0] e;
  logic [32:0] expq [$];
  logic [32:0] gotq [$];
  always @(negedge clk) begin
    if (rst) begin
      foreach (m_key[i]) begin m_key[i] = '0; m_chain[i] = '0; end
      m_blk = '0;
      m_words = 0;
      expq.delete();
      lat_wait = 0;
      hold = 0;
    end else begin
      m_idle = m_words == 0 && expq.size() == 0;
      check("dec_key", cur_dkey, m_key[sel]);
      check("in_ready", cur_in_ready, expq.size() == 0);
      check("busy", cur_busy, !m_idle);
      if (expq.size() != 0) check("dec_en_msg", cur_enc, m_blk);
      if (hold) begin
        check("hold_data", cur_out_data, hold_data);
        check("hold_last", cur_out_last, hold_last);
      end
      if (lat_wait) begin
        if (cur_out_valid) begin
          check("latency", lat_cnt, ST[sel]);
          lat_wait = 0;
        end else if (++lat_cnt > 600) begin
          fail("latency_timeout");
          lat_wait = 0;
        end
      end
      check("out_valid", cur_out_valid, expq.size() != 0 && !lat_wait);
      hold = cur_out_valid && !out_ready;
      hold_data = cur_out_data;
      hold_last = cur_out_last;
      if (cur_out_valid && out_ready) begin
        gotq.push_back({cur_out_last, cur_out_data});
        if (expq.size() == 0) check("unexpected_output", 1'b1, 1'b0);
        else begin
          e = expq.pop_front();
          check("out_data", cur_out_data, e[31:0]);
          check("out_last", cur_out_last, e[32]);
        end
      end
      if (m_idle && key_load) m_key[sel] = key_in;
      if (m_idle && iv_load) m_chain[sel] = iv_in;
      if (in_valid && cur_in_ready) begin
        m_blk = {m_blk[95:0], in_data};
        if (++m_words == 4) begin
          m_pt = aes_dec(m_blk, m_key[sel]) ^ (CB[sel] ? m_chain[sel] : '0);
          if (CB[sel]) m_chain[sel] = m_blk;
          for (int j = 0; j < 4; j++) expq.push_back({j == 3, m_pt[127-32*j -: 32]});
          m_words = 0;
          lat_wait = 1;
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] w, input int gap);
    bit ok = 0;
    int n = 0;
    repeat (gap) tick();
    in_data = w;
    in_valid = 1;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = cur_in_ready;
      tick();
      n++;
    end
    in_valid = 0;
    if (!ok) fail("send_timeout");
  endtask
  task automatic send_block(input logic [127:0] b);
    for (int j = 0; j < 4; j++) send(b[127-32*j -: 32], 0);
  endtask
  task automatic drain(input bit rnd);
    int n = 0;
    while ((expq.size() != 0 || cur_busy) && n < 2000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1;
    if (n >= 2000) fail("drain_timeout");
  endtask
  task automatic load(input logic [127:0] k, input logic [127:0] v, input bit kl, input bit il);
    key_in = k;
    iv_in = v;
    key_load = kl;
    iv_load = il;
    tick();
    key_load = 0;
    iv_load = 0;
  endtask
  task automatic check_got(input string name, input logic [127:0] p);
    check({name, "_count"}, gotq.size(), 4);
    for (int j = 0; j < 4 && j < gotq.size(); j++)
      check(name, gotq[j], {j == 3, p[127-32*j -: 32]});
  endtask

  typedef struct {
    logic [1:0] sel;
    bit kl;
    bit il;
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t tbl [4];

  initial begin
    #1000000;
    fail("watchdog");
    $fatal(1, "simulation time limit");
  end

  initial begin
    tbl[0] = '{2'd0, 1'b1, 1'b0, K, '0, C, P};
    tbl[1] = '{2'd1, 1'b1, 1'b1, K, '0, C, P};
    tbl[2] = '{2'd1, 1'b0, 1'b0, K, '0, C, P2};
    tbl[3] = '{2'd2, 1'b1, 1'b1, K, '0, C, P};
    rst = 1;
    sel = 0;
    key_in = '0;
    iv_in = '0;
    key_load = 0;
    iv_load = 0;
    in_data = '0;
    in_valid = 0;
    out_ready = 1;
    repeat (2) tick();
    for (int i = 0; i < NI; i++) begin
      sel = 2'(i);
      #1;
      check("rst_in_ready", cur_in_ready, 1'b1);
      check("rst_out_valid", cur_out_valid, 1'b0);
      check("rst_out_last", cur_out_last, 1'b0);
      check("rst_busy", cur_busy, 1'b0);
      check("rst_out_data", cur_out_data, 32'h0);
      check("rst_dec_key", cur_dkey, 128'h0);
      check("rst_dec_en_msg", cur_enc, 128'h0);
    end
    sel = 0;
    rst = 0;
    tick();
    foreach (tbl[i]) begin
      sel = tbl[i].sel;
      load(tbl[i].key, tbl[i].iv, tbl[i].kl, tbl[i].il);
      gotq.delete();
      send_block(tbl[i].ct);
      drain(0);
      check_got("tbl_word", tbl[i].pt);
    end
    // backpressure at index 1 with a key load attempted during the stall
    sel = 0;
    out_ready = 0;
    send_block(C);
    begin
      int n = 0;
      while (n < 100) begin
        @(negedge clk);
        if (cur_out_valid) break;
        n++;
      end
      if (n >= 100) fail("bp_valid_timeout");
    end
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    key_in = rnd128();
    key_load = 1;
    repeat (5) begin
      @(negedge clk);
      check("bp_data", cur_out_data, 32'h44556677);
      check("bp_in_ready", cur_in_ready, 1'b0);
      check("bp_key", cur_dkey, K);
      tick();
    end
    key_load = 0;
    drain(0);
    // sparse input with a key load attempted at count 2
    gotq.delete();
    send(C[127:96], 1);
    send(C[95:64], 1);
    key_in = rnd128();
    key_load = 1;
    tick();
    key_load = 0;
    send(C[63:32], 1);
    send(C[31:0], 1);
    drain(0);
    check_got("sparse_word", P);
    check("sparse_key", cur_dkey, K);
    // reset during the settle window
    send_block(C);
    tick();
    rst = 1;
    @(negedge clk);
    check("rst_mid_out_valid", cur_out_valid, 1'b0);
    check("rst_mid_in_ready", cur_in_ready, 1'b1);
    check("rst_mid_busy", cur_busy, 1'b0);
    tick();
    rst = 0;
    gotq.delete();
    repeat (8) tick();
    check("rst_mid_no_output", gotq.size(), 0);
    check("rst_mid_key", cur_dkey, 128'h0);
    load(K, '0, 1'b1, 1'b0);
    send_block(C);
    drain(0);
    check_got("after_rst_word", P);
    // random blocks across all instances, loads sometimes coinciding with the first word
    for (int b = 0; b < 40; b++) begin
      sel = 2'($urandom_range(0, NI - 1));
      if ($urandom_range(0, 2) == 0) begin
        key_in = rnd128();
        iv_in = rnd128();
        key_load = 1;
        iv_load = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < 4; j++) begin
        send($urandom, j == 0 ? 0 : $urandom_range(0, 2));
        key_load = 0;
        iv_load = 0;
      end
      drain(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
